// File: rtl/acc_framer_pkg.sv
// Shared constants and types for the accumulator framer: header sync word
// and the reader state encoding.
package acc_framer_pkg;

    localparam logic [15:0] HDR_SYNC = 16'hA55A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA
    } reader_state_e;

endpackage

// File: rtl/framer_fifo.sv
// First-word-fall-through synchronous FIFO, 32-bit wide, 2**AW words deep.
// The head word is always visible on rd_data_o while occupancy is non-zero.
module framer_fifo #(
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [31:0]   wr_data_i,
    input  logic          rd_en_i,
    output logic [31:0]   rd_data_o,
    output logic [AW:0]   occupancy_o
);

    localparam logic [AW:0] CAPACITY = (AW + 1)'(2 ** AW);

    logic [31:0]   mem_q [2 ** AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          push, pop;

    assign push = wr_en_i && (occ_q != CAPACITY);
    assign pop  = rd_en_i && (occ_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Storage carries no reset; clearing the pointers empties the FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign rd_data_o   = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;

endmodule

// File: rtl/acc_framer.sv
// Packs accumulator I/Q dumps into AXI-Stream frames: two header words
// (sync+sequence, drop count+length) followed by DEPTH data words.
module acc_framer
    import acc_framer_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int FIFO_AW = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din_I,
    input  logic [15:0] din_Q,
    input  logic        din_vld,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [15:0] frames_dropped,
    output logic        busy
);

    localparam int              CW       = $clog2(DEPTH);
    localparam int              PW       = FIFO_AW + 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(DEPTH - 1);
    localparam logic [PW-1:0]   CAPACITY = PW'(2 ** FIFO_AW);
    localparam logic [PW-1:0]   FRAME_SZ = PW'(DEPTH);

    logic [CW-1:0]  wr_cnt_q, wr_cnt_d;
    logic           admit_q, admit_d;
    logic [15:0]    dropped_q, dropped_d;
    logic [PW-1:0]  pending_q, pending_d;
    logic [15:0]    seq_q, seq_d;
    logic [15:0]    hdr1_q, hdr1_d;
    logic [CW-1:0]  beat_q, beat_d;
    reader_state_e  state_q, state_d;

    logic           first_sample, admit_now, fifo_wr, fifo_rd;
    logic           frame_close, frame_done;
    logic [31:0]    fifo_rd_data;
    logic [FIFO_AW:0] fifo_occ;
    logic [PW-1:0]  free_words;

    framer_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (fifo_wr),
        .wr_data_i   ({din_I, din_Q}),
        .rd_en_i     (fifo_rd),
        .rd_data_o   (fifo_rd_data),
        .occupancy_o (fifo_occ)
    );

    // The admit decision is made once per frame, so a frame is either stored
    // whole or dropped whole and the FIFO can never overflow mid-frame.
    assign free_words   = CAPACITY - fifo_occ;
    assign admit_now    = (free_words >= FRAME_SZ);
    assign first_sample = din_vld && (wr_cnt_q == '0);
    assign fifo_wr      = din_vld && (first_sample ? admit_now : admit_q);
    assign frame_close  = din_vld && (wr_cnt_q == LAST_IDX) && admit_q;

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        admit_d   = admit_q;
        dropped_d = dropped_q;
        if (din_vld) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
        end
        if (first_sample) begin
            admit_d = admit_now;
            if (!admit_now && (dropped_q != 16'hFFFF)) begin
                dropped_d = dropped_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        seq_d      = seq_q;
        hdr1_d     = hdr1_q;
        frame_done = 1'b0;
        fifo_rd    = 1'b0;
        m_tvalid   = 1'b0;
        m_tlast    = 1'b0;
        m_tdata    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0) begin
                    state_d = ST_HDR0;
                    hdr1_d  = dropped_q;
                end
            end
            ST_HDR0: begin
                m_tvalid = 1'b1;
                m_tdata  = {HDR_SYNC, seq_q};
                if (m_tready) begin
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                m_tvalid = 1'b1;
                m_tdata  = {hdr1_q, 16'(DEPTH)};
                if (m_tready) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                end
            end
            ST_DATA: begin
                m_tvalid = 1'b1;
                m_tdata  = fifo_rd_data;
                m_tlast  = (beat_q == LAST_IDX);
                fifo_rd  = m_tready;
                if (m_tready) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LAST_IDX) begin
                        state_d    = ST_IDLE;
                        frame_done = 1'b1;
                        seq_d      = seq_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case ({frame_close, frame_done})
            2'b10:   pending_d = pending_q + 1'b1;
            2'b01:   pending_d = pending_q - 1'b1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            admit_q   <= 1'b0;
            dropped_q <= '0;
            pending_q <= '0;
            seq_q     <= '0;
            hdr1_q    <= '0;
            beat_q    <= '0;
            state_q   <= ST_IDLE;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            admit_q   <= admit_d;
            dropped_q <= dropped_d;
            pending_q <= pending_d;
            seq_q     <= seq_d;
            hdr1_q    <= hdr1_d;
            beat_q    <= beat_d;
            state_q   <= state_d;
        end
    end

    assign frames_dropped = dropped_q;
    assign busy = (wr_cnt_q != '0) || (pending_q != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_acc_framer.sv
// Directed bench for acc_framer (DEPTH=16, FIFO_AW=5): table-driven frame
// content plus hand-written drop, stall, gap and reset sequences.
module tb_acc_framer;

    localparam int DEPTH   = 16;
    localparam int FIFO_AW = 5;
    localparam int BEATS   = DEPTH + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] din_I = '0;
    logic [15:0] din_Q = '0;
    logic        din_vld = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic [15:0] frames_dropped;
    logic        busy;

    always #5 clk = ~clk;

    acc_framer #(.DEPTH(DEPTH), .FIFO_AW(FIFO_AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .din_I          (din_I),
        .din_Q          (din_Q),
        .din_vld        (din_vld),
        .m_tdata        (m_tdata),
        .m_tvalid       (m_tvalid),
        .m_tready       (m_tready),
        .m_tlast        (m_tlast),
        .frames_dropped (frames_dropped),
        .busy           (busy)
    );

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [31:0] expData;
        logic        expLast;
    } vec_t;

    vec_t        vecs[DEPTH];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          lastSampleCyc = 0;
    logic [31:0] capData[$];
    logic        capLast[$];
    int          capCyc[$];
    int          riseCyc[$];
    logic        prevStall = 1'b0;
    logic        prevValid = 1'b0;
    logic [31:0] prevData = '0;
    logic        prevLast = 1'b0;
    bit          randReady = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Output monitor: captures handshakes and checks that a stalled beat holds.
    task automatic sampleOutputs();
        if (rst) begin
            prevStall = 1'b0;
            prevValid = 1'b0;
        end else begin
            if (prevStall) begin
                checkOutput("stall_valid", 32'(m_tvalid), 32'd1);
                checkOutput("stall_data", m_tdata, prevData);
                checkOutput("stall_last", 32'(m_tlast), 32'(prevLast));
            end
            if (m_tvalid && !prevValid) riseCyc.push_back(cyc);
            if (m_tvalid && m_tready) begin
                capData.push_back(m_tdata);
                capLast.push_back(m_tlast);
                capCyc.push_back(cyc);
            end
            prevStall = m_tvalid && !m_tready;
            prevData  = m_tdata;
            prevLast  = m_tlast;
            prevValid = m_tvalid;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sampleOutputs();
        @(posedge clk);
        #1;
        cyc++;
        if (randReady) m_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic clearCapture();
        capData.delete();
        capLast.delete();
        capCyc.delete();
        riseCyc.delete();
    endtask

    task automatic doReset();
        rst = 1'b1;
        din_vld = 1'b0;
        randReady = 1'b0;
        m_tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clearCapture();
    endtask

    task automatic applyStimulus(input logic [15:0] base, input int count, input int maxGap);
        logic [15:0] v;
        for (int k = 0; k < count; k++) begin
            v = base + 16'(k);
            din_I = v;
            din_Q = -v;
            din_vld = 1'b1;
            lastSampleCyc = cyc;
            tick();
            din_vld = 1'b0;
            if (maxGap > 0) begin
                repeat ($urandom_range(0, maxGap)) tick();
            end
        end
    endtask

    task automatic waitBeats(input int n, input int budget);
        int w = 0;
        while (capData.size() < n && w < budget) begin
            tick();
            w++;
        end
        if (capData.size() < n) checkOutput("beat_timeout", 32'(capData.size()), 32'(n));
    endtask

    task automatic checkFrame(input int seq, input logic [31:0] hdr1, input logic [15:0] base, input string tag);
        logic [31:0] d, e;
        logic        l;
        logic [15:0] v, nv;
        if (capData.size() < BEATS) begin
            checkOutput({tag, "_beats"}, 32'(capData.size()), 32'(BEATS));
            return;
        end
        for (int j = 0; j < BEATS; j++) begin
            d = capData.pop_front();
            l = capLast.pop_front();
            void'(capCyc.pop_front());
            if (j == 0) e = {16'hA55A, 16'(seq)};
            else if (j == 1) e = hdr1;
            else begin
                v  = base + 16'(j - 2);
                nv = -v;
                e  = {v, nv};
            end
            checkOutput($sformatf("%s_data%0d", tag, j), d, e);
            checkOutput($sformatf("%s_last%0d", tag, j), 32'(l), 32'(j == BEATS - 1));
        end
    endtask

    initial begin
        vecs[0]  = '{16'd0,  16'h0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{16'd1,  16'hFFFF, 32'h0001_FFFF, 1'b0};
        vecs[2]  = '{16'd2,  16'hFFFE, 32'h0002_FFFE, 1'b0};
        vecs[3]  = '{16'd3,  16'hFFFD, 32'h0003_FFFD, 1'b0};
        vecs[4]  = '{16'd4,  16'hFFFC, 32'h0004_FFFC, 1'b0};
        vecs[5]  = '{16'd5,  16'hFFFB, 32'h0005_FFFB, 1'b0};
        vecs[6]  = '{16'd6,  16'hFFFA, 32'h0006_FFFA, 1'b0};
        vecs[7]  = '{16'd7,  16'hFFF9, 32'h0007_FFF9, 1'b0};
        vecs[8]  = '{16'd8,  16'hFFF8, 32'h0008_FFF8, 1'b0};
        vecs[9]  = '{16'd9,  16'hFFF7, 32'h0009_FFF7, 1'b0};
        vecs[10] = '{16'd10, 16'hFFF6, 32'h000A_FFF6, 1'b0};
        vecs[11] = '{16'd11, 16'hFFF5, 32'h000B_FFF5, 1'b0};
        vecs[12] = '{16'd12, 16'hFFF4, 32'h000C_FFF4, 1'b0};
        vecs[13] = '{16'd13, 16'hFFF3, 32'h000D_FFF3, 1'b0};
        vecs[14] = '{16'd14, 16'hFFF2, 32'h000E_FFF2, 1'b0};
        vecs[15] = '{16'd15, 16'hFFF1, 32'h000F_FFF1, 1'b1};

        // Reset state.
        doReset();
        checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
        checkOutput("rst_tlast", 32'(m_tlast), 32'd0);
        checkOutput("rst_tdata", m_tdata, 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_dropped", 32'(frames_dropped), 32'd0);

        // Single burst with ready held high: latency, contiguity and content.
        $display("[TB] single frame, ready high");
        m_tready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            din_I = vecs[k].i;
            din_Q = vecs[k].q;
            din_vld = 1'b1;
            lastSampleCyc = cyc;
            tick();
            din_vld = 1'b0;
            if (k == 5) checkOutput("busy_mid", 32'(busy), 32'd1);
        end
        waitBeats(BEATS, 200);
        if (riseCyc.size() > 0) checkOutput("hdr0_latency", 32'(riseCyc[0]), 32'(lastSampleCyc + 2));
        else checkOutput("hdr0_seen", 32'(riseCyc.size()), 32'd1);
        if (capData.size() >= BEATS) begin
            checkOutput("beats_contiguous", 32'(capCyc[BEATS-1] - capCyc[0]), 32'(BEATS - 1));
            checkOutput("t1_hdr0", capData[0], 32'hA55A_0000);
            checkOutput("t1_hdr1", capData[1], 32'h0000_0010);
            checkOutput("t1_hdr0_last", 32'(capLast[0]), 32'd0);
            checkOutput("t1_hdr1_last", 32'(capLast[1]), 32'd0);
            for (int k = 0; k < DEPTH; k++) begin
                checkOutput($sformatf("t1_data%0d", k), capData[k+2], vecs[k].expData);
                checkOutput($sformatf("t1_last%0d", k), 32'(capLast[k+2]), 32'(vecs[k].expLast));
            end
        end
        repeat (5) tick();
        checkOutput("t1_idle_valid", 32'(m_tvalid), 32'd0);
        checkOutput("t1_idle_busy", 32'(busy), 32'd0);

        // Three bursts against a stalled sink: the third finds no room.
        $display("[TB] overflow drop");
        doReset();
        applyStimulus(16'h0100, DEPTH, 0);
        repeat (2) tick();
        applyStimulus(16'h0200, DEPTH, 0);
        repeat (2) tick();
        applyStimulus(16'h0300, DEPTH, 0);
        repeat (3) tick();
        checkOutput("drop_count", 32'(frames_dropped), 32'd1);
        checkOutput("hold_valid", 32'(m_tvalid), 32'd1);
        checkOutput("hold_hdr0", m_tdata, 32'hA55A_0000);
        m_tready = 1'b1;
        waitBeats(2 * BEATS, 300);
        checkFrame(0, 32'h0000_0010, 16'h0100, "t2f0");
        checkFrame(1, 32'h0001_0010, 16'h0200, "t2f1");
        repeat (40) tick();
        checkOutput("t2_extra", 32'(capData.size()), 32'd0);
        checkOutput("t2_busy", 32'(busy), 32'd0);

        // Random backpressure and input gaps over many frames.
        $display("[TB] random ready, gapped input");
        doReset();
        randReady = 1'b1;
        for (int f = 0; f < 100; f++) begin
            applyStimulus(16'(f * DEPTH), DEPTH, 2);
            repeat (40) tick();
        end
        waitBeats(100 * BEATS, 4000);
        randReady = 1'b0;
        for (int f = 0; f < 100; f++) begin
            checkFrame(f, 32'h0000_0010, 16'(f * DEPTH), $sformatf("t3f%0d", f));
        end
        checkOutput("t3_drops", 32'(frames_dropped), 32'd0);

        // Reset while one frame is stalled and another half written.
        $display("[TB] reset mid-frame");
        doReset();
        applyStimulus(16'h0400, DEPTH, 0);
        tick();
        applyStimulus(16'h0480, 8, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t4_rst_valid", 32'(m_tvalid), 32'd0);
        checkOutput("t4_rst_tdata", m_tdata, 32'd0);
        checkOutput("t4_rst_busy", 32'(busy), 32'd0);
        clearCapture();
        m_tready = 1'b1;
        applyStimulus(16'h0500, DEPTH, 1);
        waitBeats(BEATS, 200);
        checkFrame(0, 32'h0000_0010, 16'h0500, "t4");
        repeat (40) tick();
        checkOutput("t4_extra", 32'(capData.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
